usr_shift_engine: RTL

- Command-driven universal shift register stage built on the team's async-clear flip-flop style.
- Accepts a command (load, shift left, shift right, hold) over a valid/ready handshake and executes multi-bit shifts one bit per cycle.
- Signals completion with a one-cycle done pulse.
- Sits between the sequencing/control logic upstream and the register bit-cells downstream; also drives the serial outputs of the chain.

---
 rtl/usr_shift_engine.sv | 72 +++++++
 1 files changed

// File: rtl/usr_shift_engine.sv
// usr_shift_engine: command-driven universal shift register with load, bit-serial shifts and a done pulse
module usr_shift_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic left_q, left_d;
  logic accept;
  assign cmd_ready = state_q == IDLE;
  assign accept = cmd_valid && cmd_ready;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign q = data_q;
  assign sout_r = data_q[0];
  assign sout_l = data_q[WIDTH-1];
  // next-state: accept/dispatch in IDLE, one shift per edge in SHIFT, single-cycle DONE
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    rem_d = rem_q;
    left_d = left_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = DONE;
        if (cmd_op == 2'b11) data_d = cmd_data;
        else if (cmd_op != 2'b00 && cmd_cnt != '0) begin
          state_d = SHIFT;
          left_d = cmd_op[1];
          rem_d = cmd_cnt;
        end
      end
      SHIFT: begin
        data_d = left_q ? {data_q[WIDTH-2:0], sin_l} : {sin_r, data_q[WIDTH-1:1]};
        rem_d = rem_q - CNT_W'(1);
        state_d = rem_q == CNT_W'(1) ? DONE : SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; clr_n aborts any command and clears the register immediately
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      data_q <= '0;
      rem_q <= '0;
      left_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      rem_q <= rem_d;
      left_q <= left_d;
    end
  end
endmodule
